mem_responder: RTL and testbench

- Memory-side responder for the CPU core's two read ports (data and instruction fetch) and its single write port.
- Holds a word-addressed 64-bit backing store.
- Every read request gets a fixed-latency, in-order response; there is no backpressure.
- Sits outside the core, at top level and in the bench, as the reference memory; also keeps sticky error and access statistics.

---
 rtl/mem_responder_if.sv | 37 +++
 rtl/mem_responder.sv | 199 +++++++++++++++++++
 tb/tb_mem_responder.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// mem_responder_if
//   Bundles the core-side memory bus seen by mem_responder: one data read
//   port, one instruction fetch port and one write port.
//
//   master : the requester (core or bench); drives requests, receives responses
//   slave  : the responder; receives requests, drives responses
//
//   Data read  : mem_ren / mem_raddr           -> mem_rvalid / mem_rdata
//   Fetch read : mem_iren / mem_iraddr         -> mem_irvalid / mem_irdata
//   Write      : mem_wen / mem_waddr / mem_wdata
interface mem_responder_if;
    logic        mem_ren;
    logic [63:0] mem_raddr;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;

    logic        mem_iren;
    logic [63:0] mem_iraddr;
    logic        mem_irvalid;
    logic [63:0] mem_irdata;

    logic        mem_wen;
    logic [63:0] mem_waddr;
    logic [63:0] mem_wdata;

    modport master (
        output mem_ren, mem_raddr, mem_iren, mem_iraddr,
               mem_wen, mem_waddr, mem_wdata,
        input  mem_rvalid, mem_rdata, mem_irvalid, mem_irdata
    );

    modport slave (
        input  mem_ren, mem_raddr, mem_iren, mem_iraddr,
               mem_wen, mem_waddr, mem_wdata,
        output mem_rvalid, mem_rdata, mem_irvalid, mem_irdata
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder
//   Reference memory for the core: a word-addressed store of 64-bit words
//   serving a data read port and a fetch port with independent fixed
//   latencies, plus one write port. Reads are captured from the store at
//   acceptance (write-first against a same-cycle write to the same word) and
//   then delayed through a shift pipeline, so responses are in order with no
//   backpressure. Also keeps sticky error flags and saturating statistics.
//
//   Parameters
//     DEPTH_WORDS   : number of 64-bit words (power of two, >= 2)
//     DREAD_LATENCY : request-to-mem_rvalid latency in cycles (1..8)
//     IREAD_LATENCY : request-to-mem_irvalid latency in cycles (1..8)
//     INIT_FILE     : image name; the store starts zero-filled
//
//   Ports
//     clk            : clock
//     rst            : asynchronous active-high reset
//     bus            : slave side of mem_responder_if (requests in, responses out)
//     err_misaligned : sticky, some accepted access had addr[2:0] != 0
//     err_range      : sticky, some accepted access had word index >= DEPTH_WORDS
//     rd_count       : saturating count of accepted data + fetch reads
//     wr_count       : saturating count of accepted writes (dropped ones too)
module mem_responder #(
    parameter int unsigned DEPTH_WORDS   = 1024,
    parameter int unsigned DREAD_LATENCY = 2,
    parameter int unsigned IREAD_LATENCY = 1,
    parameter string       INIT_FILE     = ""
) (
    input  logic              clk,
    input  logic              rst,
    mem_responder_if.slave    bus,
    output logic              err_misaligned,
    output logic              err_range,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    typedef logic [63:0] store_t [DEPTH_WORDS];

    // A byte address is in range when every word-index bit above the array
    // width is zero; only then is the truncated index used to touch the store.
    function automatic logic in_range(input logic [63:0] addr);
        return (addr[63:3+IDX_W] == '0);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [63:0] addr);
        return addr[3+IDX_W-1:3];
    endfunction

    function automatic logic misaligned(input logic [63:0] addr);
        return (addr[2:0] != 3'b000);
    endfunction

    // ------------------------------------------------------------------
    // Backing store: zero-filled at elaboration.
    // ------------------------------------------------------------------
    store_t store = '{default: '0};

    logic        wr_ok;
    logic [63:0] drd_word;
    logic [63:0] ird_word;

    // Read values as seen at acceptance. A same-cycle write to the same word
    // wins (write-first); out-of-range reads return zero.
    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ok    = bus.mem_wen && in_range(bus.mem_waddr);
        drd_word = '0;
        ird_word = '0;
        if (in_range(bus.mem_raddr)) begin
            if (wr_ok && (word_idx(bus.mem_waddr) == word_idx(bus.mem_raddr))) begin
                drd_word = bus.mem_wdata;
            end else begin
                drd_word = store[word_idx(bus.mem_raddr)];
            end
        end
        if (in_range(bus.mem_iraddr)) begin
            if (wr_ok && (word_idx(bus.mem_waddr) == word_idx(bus.mem_iraddr))) begin
                ird_word = bus.mem_wdata;
            end else begin
                ird_word = store[word_idx(bus.mem_iraddr)];
            end
        end
    end

    // NOTE: the store is deliberately kept out of the reset domain; it keeps
    // its contents across rst and maps onto plain RAM. Writes are still
    // suppressed at an edge where rst is high.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            store[word_idx(bus.mem_waddr)] <= bus.mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Read pipelines: stage 0 captures at acceptance, the last stage is the
    // output register. A stage's data only moves when its predecessor holds a
    // valid entry, so the output data holds its last value between responses.
    // ------------------------------------------------------------------
    logic [DREAD_LATENCY-1:0]       dvalid_q, dvalid_d;
    logic [DREAD_LATENCY-1:0][63:0] ddata_q,  ddata_d;
    logic [IREAD_LATENCY-1:0]       ivalid_q, ivalid_d;
    logic [IREAD_LATENCY-1:0][63:0] idata_q,  idata_d;

    always_comb begin
        dvalid_d    = '0;
        ddata_d     = ddata_q;
        dvalid_d[0] = bus.mem_ren;
        if (bus.mem_ren) begin
            ddata_d[0] = drd_word;
        end
        for (int i = 1; i < int'(DREAD_LATENCY); i++) begin
            dvalid_d[i] = dvalid_q[i-1];
            if (dvalid_q[i-1]) begin
                ddata_d[i] = ddata_q[i-1];
            end
        end
    end

    always_comb begin
        ivalid_d    = '0;
        idata_d     = idata_q;
        ivalid_d[0] = bus.mem_iren;
        if (bus.mem_iren) begin
            idata_d[0] = ird_word;
        end
        for (int i = 1; i < int'(IREAD_LATENCY); i++) begin
            ivalid_d[i] = ivalid_q[i-1];
            if (ivalid_q[i-1]) begin
                idata_d[i] = idata_q[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky errors and saturating statistics
    // ------------------------------------------------------------------
    logic        err_mis_q, err_mis_d;
    logic        err_rng_q, err_rng_d;
    logic [31:0] rd_count_q, rd_count_d;
    logic [31:0] wr_count_q, wr_count_d;
    logic [32:0] rd_sum;
    logic [32:0] wr_sum;

    always_comb begin
        err_mis_d = err_mis_q
                 || (bus.mem_ren  && misaligned(bus.mem_raddr))
                 || (bus.mem_iren && misaligned(bus.mem_iraddr))
                 || (bus.mem_wen  && misaligned(bus.mem_waddr));
        err_rng_d = err_rng_q
                 || (bus.mem_ren  && !in_range(bus.mem_raddr))
                 || (bus.mem_iren && !in_range(bus.mem_iraddr))
                 || (bus.mem_wen  && !in_range(bus.mem_waddr));

        // One extra bit catches the wrap so the count pins at all-ones.
        rd_sum     = {1'b0, rd_count_q} + {32'd0, bus.mem_ren} + {32'd0, bus.mem_iren};
        wr_sum     = {1'b0, wr_count_q} + {32'd0, bus.mem_wen};
        rd_count_d = rd_sum[32] ? '1 : rd_sum[31:0];
        wr_count_d = wr_sum[32] ? '1 : wr_sum[31:0];
    end

    // Reset discards in-flight responses along with statistics and errors.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvalid_q   <= '0;
            ddata_q    <= '0;
            ivalid_q   <= '0;
            idata_q    <= '0;
            err_mis_q  <= 1'b0;
            err_rng_q  <= 1'b0;
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            dvalid_q   <= dvalid_d;
            ddata_q    <= ddata_d;
            ivalid_q   <= ivalid_d;
            idata_q    <= idata_d;
            err_mis_q  <= err_mis_d;
            err_rng_q  <= err_rng_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign bus.mem_rvalid  = dvalid_q[DREAD_LATENCY-1];
    assign bus.mem_rdata   = ddata_q[DREAD_LATENCY-1];
    assign bus.mem_irvalid = ivalid_q[IREAD_LATENCY-1];
    assign bus.mem_irdata  = idata_q[IREAD_LATENCY-1];
    assign err_misaligned  = err_mis_q;
    assign err_range       = err_rng_q;
    assign rd_count        = rd_count_q;
    assign wr_count        = wr_count_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Drives two responders with identical stimulus: instance A with the default
//   latencies (data 2, fetch 1) and instance B with data 3, fetch 1. A
//   behavioural model (sparse word store, per-cycle expected-response tables,
//   plain counters) predicts every output and is compared each cycle on the
//   falling edge. Directed scenarios come first, then randomized traffic with
//   occasional resets.
module tb_mem_responder;

    localparam int DEPTH  = 1024;
    localparam int A_DLAT = 2;
    localparam int A_ILAT = 1;
    localparam int B_DLAT = 3;
    localparam int B_ILAT = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        ren    = 1'b0;
    logic        iren   = 1'b0;
    logic        wen    = 1'b0;
    logic [63:0] raddr  = '0;
    logic [63:0] iraddr = '0;
    logic [63:0] waddr  = '0;
    logic [63:0] wdata  = '0;

    mem_responder_if bus_a();
    mem_responder_if bus_b();

    assign bus_a.mem_ren    = ren;
    assign bus_a.mem_raddr  = raddr;
    assign bus_a.mem_iren   = iren;
    assign bus_a.mem_iraddr = iraddr;
    assign bus_a.mem_wen    = wen;
    assign bus_a.mem_waddr  = waddr;
    assign bus_a.mem_wdata  = wdata;
    assign bus_b.mem_ren    = ren;
    assign bus_b.mem_raddr  = raddr;
    assign bus_b.mem_iren   = iren;
    assign bus_b.mem_iraddr = iraddr;
    assign bus_b.mem_wen    = wen;
    assign bus_b.mem_waddr  = waddr;
    assign bus_b.mem_wdata  = wdata;

    logic        err_mis_a, err_rng_a, err_mis_b, err_rng_b;
    logic [31:0] rd_count_a, wr_count_a, rd_count_b, wr_count_b;

    mem_responder #(.DEPTH_WORDS(DEPTH), .DREAD_LATENCY(A_DLAT), .IREAD_LATENCY(A_ILAT)) u_dut_a (
        .clk(clk), .rst(rst), .bus(bus_a),
        .err_misaligned(err_mis_a), .err_range(err_rng_a),
        .rd_count(rd_count_a), .wr_count(wr_count_a)
    );

    mem_responder #(.DEPTH_WORDS(DEPTH), .DREAD_LATENCY(B_DLAT), .IREAD_LATENCY(B_ILAT)) u_dut_b (
        .clk(clk), .rst(rst), .bus(bus_b),
        .err_misaligned(err_mis_b), .err_range(err_rng_b),
        .rd_count(rd_count_b), .wr_count(wr_count_b)
    );

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [63:0] model_mem [int];
    // Expected response data keyed by the edge number after which it shows.
    logic [63:0] exp_ad [int];
    logic [63:0] exp_ai [int];
    logic [63:0] exp_bd [int];
    logic [63:0] exp_bi [int];
    logic [63:0] last_ad = '0, last_ai = '0, last_bd = '0, last_bi = '0;
    logic        exp_mis = 1'b0;
    logic        exp_rng = 1'b0;
    longint      exp_rd  = 0;
    longint      exp_wr  = 0;
    int          edge_n  = 0;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d got=%h exp=%h", tag, edge_n, got, exp);
        end
    endtask

    // Value a read of addr returns when accepted at the current edge.
    function automatic logic [63:0] model_read(input logic [63:0] addr);
        logic [63:0] idx;
        idx = addr >> 3;
        if (idx >= 64'(DEPTH)) return '0;
        if (wen && ((waddr >> 3) == idx)) return wdata;
        if (model_mem.exists(int'(idx))) return model_mem[int'(idx)];
        return '0;
    endfunction

    function automatic logic bad_range(input logic [63:0] addr);
        return (addr >> 3) >= 64'(DEPTH);
    endfunction

    task automatic model_accept();
        logic [63:0] v;
        if (ren) begin
            v = model_read(raddr);
            exp_ad[edge_n + A_DLAT - 1] = v;
            exp_bd[edge_n + B_DLAT - 1] = v;
            if (raddr[2:0] != 3'b000) exp_mis = 1'b1;
            if (bad_range(raddr)) exp_rng = 1'b1;
        end
        if (iren) begin
            v = model_read(iraddr);
            exp_ai[edge_n + A_ILAT - 1] = v;
            exp_bi[edge_n + B_ILAT - 1] = v;
            if (iraddr[2:0] != 3'b000) exp_mis = 1'b1;
            if (bad_range(iraddr)) exp_rng = 1'b1;
        end
        if (wen) begin
            if (waddr[2:0] != 3'b000) exp_mis = 1'b1;
            if (bad_range(waddr)) exp_rng = 1'b1;
            else model_mem[int'(waddr >> 3)] = wdata;
        end
        exp_rd += int'(ren) + int'(iren);
        exp_wr += int'(wen);
        if (exp_rd > 64'hFFFF_FFFF) exp_rd = 64'hFFFF_FFFF;
        if (exp_wr > 64'hFFFF_FFFF) exp_wr = 64'hFFFF_FFFF;
    endtask

    task automatic compare();
        logic e;
        e = exp_ad.exists(edge_n);
        if (e) begin last_ad = exp_ad[edge_n]; exp_ad.delete(edge_n); end
        check("a_rvalid", 64'(bus_a.mem_rvalid), 64'(e));
        check("a_rdata", bus_a.mem_rdata, last_ad);
        e = exp_ai.exists(edge_n);
        if (e) begin last_ai = exp_ai[edge_n]; exp_ai.delete(edge_n); end
        check("a_irvalid", 64'(bus_a.mem_irvalid), 64'(e));
        check("a_irdata", bus_a.mem_irdata, last_ai);
        e = exp_bd.exists(edge_n);
        if (e) begin last_bd = exp_bd[edge_n]; exp_bd.delete(edge_n); end
        check("b_rvalid", 64'(bus_b.mem_rvalid), 64'(e));
        check("b_rdata", bus_b.mem_rdata, last_bd);
        e = exp_bi.exists(edge_n);
        if (e) begin last_bi = exp_bi[edge_n]; exp_bi.delete(edge_n); end
        check("b_irvalid", 64'(bus_b.mem_irvalid), 64'(e));
        check("b_irdata", bus_b.mem_irdata, last_bi);
        check("a_err_mis", 64'(err_mis_a), 64'(exp_mis));
        check("a_err_rng", 64'(err_rng_a), 64'(exp_rng));
        check("b_err_mis", 64'(err_mis_b), 64'(exp_mis));
        check("b_err_rng", 64'(err_rng_b), 64'(exp_rng));
        check("a_rd_count", 64'(rd_count_a), 64'(exp_rd));
        check("a_wr_count", 64'(wr_count_a), 64'(exp_wr));
        check("b_rd_count", 64'(rd_count_b), 64'(exp_rd));
        check("b_wr_count", 64'(wr_count_b), 64'(exp_wr));
    endtask

    // One clock: the model accepts what the DUTs see at the rising edge, and
    // outputs are compared at the following falling edge.
    task automatic cycle();
        @(posedge clk);
        edge_n++;
        if (!rst) model_accept();
        @(negedge clk);
        compare();
    endtask

    task automatic drive(input logic r, input logic [63:0] ra,
                         input logic i, input logic [63:0] ia,
                         input logic w, input logic [63:0] wa, input logic [63:0] wd);
        ren = r; raddr = ra; iren = i; iraddr = ia;
        wen = w; waddr = wa; wdata = wd;
        cycle();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, '0, 0, '0, 0, '0, '0);
    endtask

    // Asserted just after a falling edge: anything in flight is dropped.
    task automatic do_reset();
        ren = 0; iren = 0; wen = 0;
        rst = 1'b1;
        exp_ad.delete(); exp_ai.delete(); exp_bd.delete(); exp_bi.delete();
        last_ad = '0; last_ai = '0; last_bd = '0; last_bi = '0;
        exp_mis = 1'b0; exp_rng = 1'b0; exp_rd = 0; exp_wr = 0;
        cycle();
        rst = 1'b0;
    endtask

    function automatic logic [63:0] pick_addr();
        int unsigned sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) return {$urandom, $urandom};
        if (sel == 1) return (64'($urandom_range(0, 15)) << 3) | 64'($urandom_range(1, 7));
        return 64'($urandom_range(0, 15)) << 3;
    endfunction

    initial begin
        #1 rst = 1'b1;
        @(negedge clk);
        compare();
        rst = 1'b0;

        // Write then read with data latency 2.
        drive(0, '0, 0, '0, 1, 64'h40, 64'hDEAD_BEEF_0000_0001);
        drive(1, 64'h40, 0, '0, 0, '0, '0);
        idle(4);

        // Preload words 0..3, clear statistics, then four back-to-back reads.
        drive(0, '0, 0, '0, 1, 64'h00, 64'd1);
        drive(0, '0, 0, '0, 1, 64'h08, 64'd2);
        drive(0, '0, 0, '0, 1, 64'h10, 64'd3);
        drive(0, '0, 0, '0, 1, 64'h18, 64'd4);
        do_reset();
        drive(1, 64'h00, 0, '0, 0, '0, '0);
        drive(1, 64'h08, 0, '0, 0, '0, '0);
        drive(1, 64'h10, 0, '0, 0, '0, '0);
        drive(1, 64'h18, 0, '0, 0, '0, '0);
        idle(4);
        check("pipe_rd_count", 64'(rd_count_a), 64'd4);

        // Collision: an earlier read keeps the old word, same-cycle reads see the write.
        drive(0, '0, 0, '0, 1, 64'h20, 64'hAA);
        drive(1, 64'h20, 0, '0, 0, '0, '0);
        drive(1, 64'h20, 1, 64'h20, 1, 64'h20, 64'h55);
        idle(4);

        // Misaligned read returns word 0; out-of-range write is dropped but counted.
        do_reset();
        drive(1, 64'h3, 0, '0, 0, '0, '0);
        drive(0, '0, 0, '0, 1, 64'(DEPTH) * 8, 64'hBAD0_BAD0_BAD0_BAD0);
        idle(3);
        check("drop_wr_count", 64'(wr_count_a), 64'd1);
        drive(1, 64'h0, 1, 64'h0, 0, '0, '0);
        idle(4);

        // Reset while a read is in flight; the store survives it.
        drive(1, 64'h40, 1, 64'h40, 0, '0, '0);
        do_reset();
        idle(4);
        drive(1, 64'h40, 1, 64'h20, 0, '0, '0);
        idle(4);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                drive(1'($urandom_range(0, 1)), pick_addr(),
                      1'($urandom_range(0, 1)), pick_addr(),
                      1'($urandom_range(0, 9) < 4), pick_addr(), {$urandom, $urandom});
            end
        end
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
